// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle controller: state encodings,
// opcode constants, PC source selects and the control-strobe bundle.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_WB_ALU   = 4'd7,
        ST_WB_MEM   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_HALT     = 4'd11
    } state_e;

    typedef enum logic [1:0] {
        PC_SRC_SEQ    = 2'd0,   // PC + 4
        PC_SRC_BRANCH = 2'd1,   // branch target
        PC_SRC_JUMP   = 2'd2    // jump target
    } pc_src_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef struct packed {
        logic    pc_write;
        logic    pc_write_cond;
        pc_src_e pc_src;
        logic    ir_write;
        logic    mem_read;
        logic    mem_write;
        logic    iord;
        logic    reg_write;
        logic    reg_dst;
        logic    alu_src;
        logic    mem_to_reg;
    } ctrl_t;

    // First execution state for an opcode; anything unrecognised halts.
    function automatic state_e dispatch(input logic [5:0] op);
        state_e nxt;
        case (op)
            OP_RTYPE:                                 nxt = ST_EXEC_R;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI: nxt = ST_EXEC_I;
            OP_LW, OP_SW:                             nxt = ST_MEM_ADDR;
            OP_BEQ, OP_BNE:                           nxt = ST_BRANCH;
            OP_J:                                     nxt = ST_JUMP;
            default:                                  nxt = ST_HALT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath bundle: opcode and memory-ready in, strobes and
// status out. The controller is the master; the datapath is the slave.
interface mc_if;
    logic [5:0]  opcode_in;
    logic        mem_ready_in;
    logic        pc_write_out;
    logic        pc_write_cond_out;
    logic [1:0]  pc_src_out;
    logic        ir_write_out;
    logic        mem_read_out;
    logic        mem_write_out;
    logic        iord_out;
    logic        reg_write_out;
    logic        reg_dst_out;
    logic        alu_src_out;
    logic        mem_to_reg_out;
    logic [3:0]  state_out;
    logic [31:0] retired_out;
    logic        illegal_out;
    logic        timeout_out;

    modport master (
        input  opcode_in, mem_ready_in,
        output pc_write_out, pc_write_cond_out, pc_src_out, ir_write_out,
               mem_read_out, mem_write_out, iord_out, reg_write_out,
               reg_dst_out, alu_src_out, mem_to_reg_out, state_out,
               retired_out, illegal_out, timeout_out
    );

    modport slave (
        output opcode_in, mem_ready_in,
        input  pc_write_out, pc_write_cond_out, pc_src_out, ir_write_out,
               mem_read_out, mem_write_out, iord_out, reg_write_out,
               reg_dst_out, alu_src_out, mem_to_reg_out, state_out,
               retired_out, illegal_out, timeout_out
    );
endinterface

// File: rtl/mc_wait_timer.sv
// Consecutive memory-miss counter. expired_o flags that the next miss
// would be the LIMIT-th in a row, so the FSM can abort on that miss while
// a ready in the same cycle still wins.
module mc_wait_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic count_i,
    output logic expired_o
);
    localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear has priority; counting stops at LAST because the FSM aborts there.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_i && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking so every register samples pre-edge values.
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end

    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle CPU control FSM: Moore-decoded strobes (FETCH's IR/PC load
// also needs mem_ready_in), retired-instruction counter, sticky illegal and
// timeout flags, memory-wait timeout via mc_wait_timer.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    mc_if.master bus
);
    state_e      state_q, state_d;
    logic [31:0] retired_q, retired_d;
    logic        illegal_q, illegal_d;
    logic        timeout_q, timeout_d;
    logic        r_type_q, r_type_d;     // remembers EXEC_R vs EXEC_I for WB_ALU
    logic        retire;
    logic        wait_count;
    logic        wait_clear;
    logic        wait_last;
    ctrl_t       ctrl_c;
    ctrl_t       ctrl_o;

    mc_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_wait_timer (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (wait_clear),
        .count_i   (wait_count),
        .expired_o (wait_last)
    );

    // Next-state, strobe decode, retire and fault detection.
    always_comb begin
        // NOTE: every output defaulted first so no path leaves a latch.
        state_d    = state_q;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;
        r_type_d   = r_type_q;
        retire     = 1'b0;
        wait_count = 1'b0;
        ctrl_c     = '0;

        case (state_q)
            ST_FETCH: begin
                ctrl_c.mem_read = 1'b1;
                if (bus.mem_ready_in) begin
                    ctrl_c.ir_write = 1'b1;
                    ctrl_c.pc_write = 1'b1;
                    ctrl_c.pc_src   = PC_SRC_SEQ;
                    state_d         = ST_DECODE;
                end else begin
                    wait_count = 1'b1;
                    if (wait_last) begin
                        state_d   = ST_HALT;
                        timeout_d = 1'b1;
                    end
                end
            end
            ST_DECODE: begin
                state_d = dispatch(bus.opcode_in);
                if (state_d == ST_HALT) illegal_d = 1'b1;
            end
            ST_EXEC_R: begin
                r_type_d = 1'b1;
                state_d  = ST_WB_ALU;
            end
            ST_EXEC_I: begin
                ctrl_c.alu_src = 1'b1;
                r_type_d       = 1'b0;
                state_d        = ST_WB_ALU;
            end
            ST_MEM_ADDR: begin
                ctrl_c.alu_src = 1'b1;
                if (bus.opcode_in == OP_LW) begin
                    state_d = ST_MEM_RD;
                end else if (bus.opcode_in == OP_SW) begin
                    state_d = ST_MEM_WR;
                end else begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end
            end
            ST_MEM_RD: begin
                ctrl_c.mem_read = 1'b1;
                ctrl_c.iord     = 1'b1;
                if (bus.mem_ready_in) begin
                    state_d = ST_WB_MEM;
                end else begin
                    wait_count = 1'b1;
                    if (wait_last) begin
                        state_d   = ST_HALT;
                        timeout_d = 1'b1;
                    end
                end
            end
            ST_MEM_WR: begin
                ctrl_c.mem_write = 1'b1;
                ctrl_c.iord      = 1'b1;
                if (bus.mem_ready_in) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end else begin
                    wait_count = 1'b1;
                    if (wait_last) begin
                        state_d   = ST_HALT;
                        timeout_d = 1'b1;
                    end
                end
            end
            ST_WB_ALU: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.reg_dst   = r_type_q;
                state_d          = ST_FETCH;
                retire           = 1'b1;
            end
            ST_WB_MEM: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
                state_d           = ST_FETCH;
                retire            = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_c.pc_write_cond = 1'b1;
                ctrl_c.pc_src        = PC_SRC_BRANCH;
                state_d              = ST_FETCH;
                retire               = 1'b1;
            end
            ST_JUMP: begin
                ctrl_c.pc_write = 1'b1;
                ctrl_c.pc_src   = PC_SRC_JUMP;
                state_d         = ST_FETCH;
                retire          = 1'b1;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase

        retired_d = retire ? retired_q + 32'd1 : retired_q;
    end

    // Any state change restarts the miss count, covering entry to each wait state.
    assign wait_clear = (state_d != state_q);

    // State and status registers; reset also aborts any access in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            retired_q <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            r_type_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            r_type_q  <= r_type_d;
        end
    end

    // Strobes are forced low for as long as reset is held.
    assign ctrl_o = reset ? ctrl_c : '0;

    assign bus.pc_write_out      = ctrl_o.pc_write;
    assign bus.pc_write_cond_out = ctrl_o.pc_write_cond;
    assign bus.pc_src_out        = ctrl_o.pc_src;
    assign bus.ir_write_out      = ctrl_o.ir_write;
    assign bus.mem_read_out      = ctrl_o.mem_read;
    assign bus.mem_write_out     = ctrl_o.mem_write;
    assign bus.iord_out          = ctrl_o.iord;
    assign bus.reg_write_out     = ctrl_o.reg_write;
    assign bus.reg_dst_out       = ctrl_o.reg_dst;
    assign bus.alu_src_out       = ctrl_o.alu_src;
    assign bus.mem_to_reg_out    = ctrl_o.mem_to_reg;
    assign bus.state_out         = state_q;
    assign bus.retired_out       = retired_q;
    assign bus.illegal_out       = illegal_q;
    assign bus.timeout_out       = timeout_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (TIMEOUT_CYCLES = 4): a cycle-by-
// cycle vector table, then hand sequences for illegal halt, reset during a
// store, and retired-counter wrap.
module tb_multicycle_control;

    logic clock;
    logic reset;
    mc_if bus ();

    multicycle_control #(.TIMEOUT_CYCLES(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        rst_n;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [11:0] ctl;
        logic [31:0] ret;
        logic        ill;
        logic        tmo;
    } vec_t;

    vec_t vecs[$];

    // {pc_write, pc_write_cond, pc_src[1:0], ir_write, mem_read, mem_write,
    //  iord, reg_write, reg_dst, alu_src, mem_to_reg}
    function automatic logic [11:0] get_ctl();
        return {bus.pc_write_out, bus.pc_write_cond_out, bus.pc_src_out,
                bus.ir_write_out, bus.mem_read_out, bus.mem_write_out,
                bus.iord_out, bus.reg_write_out, bus.reg_dst_out,
                bus.alu_src_out, bus.mem_to_reg_out};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [5:0] op, input logic rdy,
                       input logic [3:0] st, input logic [11:0] ctl,
                       input logic [31:0] ret, input logic ill, input logic tmo);
        vec_t v;
        v.rst_n = r; v.op = op; v.rdy = rdy; v.st = st;
        v.ctl = ctl; v.ret = ret; v.ill = ill; v.tmo = tmo;
        vecs.push_back(v);
    endtask

    // One cycle: drive after the falling edge, let outputs settle.
    task automatic drive(input logic r, input logic [5:0] op, input logic rdy);
        @(negedge clock);
        reset            = r;
        bus.opcode_in    = op;
        bus.mem_ready_in = rdy;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset            = 1'b0;
        bus.opcode_in    = 6'h00;
        bus.mem_ready_in = 1'b0;
        repeat (2) @(posedge clock);

        // rst op rdy  state ctl     retired ill tmo
        add(0, 6'h00, 0,  0, 12'h000, 0, 0, 0);
        // R-type, ready high: 0,1,2,7
        add(1, 6'h00, 1,  0, 12'h8C0, 0, 0, 0);
        add(1, 6'h00, 1,  1, 12'h000, 0, 0, 0);
        add(1, 6'h00, 1,  2, 12'h000, 0, 0, 0);
        add(1, 6'h00, 1,  7, 12'h00C, 0, 0, 0);
        // addi
        add(1, 6'h08, 1,  0, 12'h8C0, 1, 0, 0);
        add(1, 6'h08, 1,  1, 12'h000, 1, 0, 0);
        add(1, 6'h08, 1,  3, 12'h002, 1, 0, 0);
        add(1, 6'h08, 1,  7, 12'h008, 1, 0, 0);
        // lw with three misses in MEM_RD: 8 cycles total
        add(1, 6'h23, 1,  0, 12'h8C0, 2, 0, 0);
        add(1, 6'h23, 1,  1, 12'h000, 2, 0, 0);
        add(1, 6'h23, 1,  4, 12'h002, 2, 0, 0);
        add(1, 6'h23, 0,  5, 12'h050, 2, 0, 0);
        add(1, 6'h23, 0,  5, 12'h050, 2, 0, 0);
        add(1, 6'h23, 0,  5, 12'h050, 2, 0, 0);
        add(1, 6'h23, 1,  5, 12'h050, 2, 0, 0);
        add(1, 6'h23, 1,  8, 12'h009, 2, 0, 0);
        // sw
        add(1, 6'h2B, 1,  0, 12'h8C0, 3, 0, 0);
        add(1, 6'h2B, 1,  1, 12'h000, 3, 0, 0);
        add(1, 6'h2B, 1,  4, 12'h002, 3, 0, 0);
        add(1, 6'h2B, 1,  6, 12'h030, 3, 0, 0);
        // bne
        add(1, 6'h05, 1,  0, 12'h8C0, 4, 0, 0);
        add(1, 6'h05, 1,  1, 12'h000, 4, 0, 0);
        add(1, 6'h05, 1,  9, 12'h500, 4, 0, 0);
        // j
        add(1, 6'h02, 1,  0, 12'h8C0, 5, 0, 0);
        add(1, 6'h02, 1,  1, 12'h000, 5, 0, 0);
        add(1, 6'h02, 1, 10, 12'hA00, 5, 0, 0);
        // andi, fetch ready arrives on the 4th cycle: ready wins
        add(1, 6'h0C, 0,  0, 12'h040, 6, 0, 0);
        add(1, 6'h0C, 0,  0, 12'h040, 6, 0, 0);
        add(1, 6'h0C, 0,  0, 12'h040, 6, 0, 0);
        add(1, 6'h0C, 1,  0, 12'h8C0, 6, 0, 0);
        add(1, 6'h0C, 1,  1, 12'h000, 6, 0, 0);
        add(1, 6'h0C, 1,  3, 12'h002, 6, 0, 0);
        add(1, 6'h0C, 1,  7, 12'h008, 6, 0, 0);
        // fetch never ready: halt with timeout after 4 cycles
        add(1, 6'h0C, 0,  0, 12'h040, 7, 0, 0);
        add(1, 6'h0C, 0,  0, 12'h040, 7, 0, 0);
        add(1, 6'h0C, 0,  0, 12'h040, 7, 0, 0);
        add(1, 6'h0C, 0,  0, 12'h040, 7, 0, 0);
        add(1, 6'h0C, 1, 11, 12'h000, 7, 0, 1);
        add(1, 6'h0C, 1, 11, 12'h000, 7, 0, 1);
        // reset clears everything
        add(0, 6'h00, 1, 11, 12'h000, 7, 0, 1);
        add(1, 6'h00, 0,  0, 12'h040, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].op, vecs[i].rdy);
            check($sformatf("v%0d.state", i), 32'(bus.state_out), 32'(vecs[i].st));
            check($sformatf("v%0d.ctrl", i), 32'(get_ctl()), 32'(vecs[i].ctl));
            check($sformatf("v%0d.retired", i), bus.retired_out, vecs[i].ret);
            check($sformatf("v%0d.flags", i), 32'({bus.illegal_out, bus.timeout_out}),
                  32'({vecs[i].ill, vecs[i].tmo}));
        end

        // Illegal opcode: halt, flag, no strobes for 20 cycles, then reset.
        drive(0, 6'h3F, 1);
        drive(1, 6'h3F, 1);
        check("ill.fetch", 32'(bus.state_out), 32'd0);
        drive(1, 6'h3F, 1);
        check("ill.decode", 32'(bus.state_out), 32'd1);
        drive(1, 6'h3F, 1);
        check("ill.halt", 32'(bus.state_out), 32'd11);
        check("ill.flag", 32'(bus.illegal_out), 32'd1);
        for (int i = 0; i < 20; i++) begin
            drive(1, 6'h3F, i[0]);
            check($sformatf("ill.hold%0d.state", i), 32'(bus.state_out), 32'd11);
            check($sformatf("ill.hold%0d.ctrl", i), 32'(get_ctl()), 32'd0);
        end
        drive(0, 6'h00, 0);
        drive(1, 6'h00, 0);
        check("ill.rst.state", 32'(bus.state_out), 32'd0);
        check("ill.rst.flags", 32'({bus.illegal_out, bus.timeout_out}), 32'd0);

        // Reset during MEM_WR aborts the store without retiring it.
        drive(1, 6'h02, 1);
        drive(1, 6'h02, 1);
        drive(1, 6'h02, 1);
        drive(1, 6'h2B, 1);
        check("swrst.pre_retired", bus.retired_out, 32'd1);
        drive(1, 6'h2B, 1);
        drive(1, 6'h2B, 1);
        drive(1, 6'h2B, 0);
        check("swrst.memwr.state", 32'(bus.state_out), 32'd6);
        check("swrst.memwr.strobe", 32'(bus.mem_write_out), 32'd1);
        drive(0, 6'h2B, 0);
        check("swrst.in_reset.ctrl", 32'(get_ctl()), 32'd0);
        drive(1, 6'h2B, 0);
        check("swrst.after.state", 32'(bus.state_out), 32'd0);
        check("swrst.after.mem_write", 32'(bus.mem_write_out), 32'd0);
        check("swrst.after.retired", bus.retired_out, 32'd0);
        check("swrst.after.ctrl", 32'(get_ctl()), 32'h040);

        // Retired counter wrap: preload 0xFFFFFFFE, then two jumps.
        @(negedge clock);
        bus.mem_ready_in = 1'b0;
        bus.opcode_in    = 6'h02;
        force dut.retired_q = 32'hFFFF_FFFE;
        @(posedge clock);
        #1 release dut.retired_q;
        drive(1, 6'h02, 1);
        check("wrap.preload", bus.retired_out, 32'hFFFF_FFFE);
        drive(1, 6'h02, 1);
        drive(1, 6'h02, 1);
        check("wrap.jump.state", 32'(bus.state_out), 32'd10);
        drive(1, 6'h02, 1);
        check("wrap.first", bus.retired_out, 32'hFFFF_FFFF);
        drive(1, 6'h02, 1);
        drive(1, 6'h02, 1);
        drive(1, 6'h02, 1);
        check("wrap.second", bus.retired_out, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, memory-wait cycles before timeout abort.
REQ-002 clock  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-low.
REQ-004 opcode_in  input  6  opcode field of current instruction register.
REQ-005 mem_ready_in  input  1  memory/serial access complete this cycle.
REQ-006 pc_write_out  output  1  unconditional PC load.
REQ-007 pc_write_cond_out  output  1  PC load if branch condition true.
REQ-008 pc_src_out  output  2  PC source: 0 = PC+4, 1 = branch target, 2 = jump target.
REQ-009 ir_write_out  output  1  instruction register load.
REQ-010 mem_read_out, mem_write_out  output  1 each  memory strobes.
REQ-011 iord_out  output  1  memory address source: 0 = PC, 1 = ALU result.
REQ-012 reg_write_out, reg_dst_out, alu_src_out, mem_to_reg_out  output  1 each  datapath selects.
REQ-013 state_out  output  4  current state encoding.
REQ-014 retired_out  output  32  retired-instruction count.
REQ-015 illegal_out, timeout_out  output  1 each  sticky fault flags.

Function
REQ-016 States SHALL be FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, JUMP=10, HALT=11; codes 12-15 go to HALT.
REQ-017 All outputs SHALL be Moore (state-decoded), except pc_write_out and ir_write_out in FETCH, which also require mem_ready_in.
REQ-018 FETCH: mem_read_out=1, iord_out=0; on mem_ready_in: ir_write_out=1, pc_write_out=1, pc_src_out=0, go DECODE; else hold.
REQ-019 DECODE dispatch: 0x00 -> EXEC_R; 0x08/0x09/0x0A/0x0C/0x0D -> EXEC_I; 0x23/0x2B -> MEM_ADDR; 0x04/0x05 -> BRANCH; 0x02 -> JUMP; other -> HALT with illegal_out set.
REQ-020 EXEC_R: alu_src_out=0 -> WB_ALU with reg_dst_out=1; EXEC_I: alu_src_out=1 -> WB_ALU with reg_dst_out=0.
REQ-021 MEM_ADDR: alu_src_out=1; 0x23 -> MEM_RD, 0x2B -> MEM_WR.
REQ-022 MEM_RD: mem_read_out=1, iord_out=1; on mem_ready_in -> WB_MEM. MEM_WR: mem_write_out=1, iord_out=1; on mem_ready_in -> FETCH.
REQ-023 WB_ALU: reg_write_out=1, mem_to_reg_out=0; WB_MEM: reg_write_out=1, mem_to_reg_out=1, reg_dst_out=0; both -> FETCH.
REQ-024 BRANCH: pc_write_cond_out=1, pc_src_out=1, one cycle -> FETCH. JUMP: pc_write_out=1, pc_src_out=2, one cycle -> FETCH.
REQ-025 Latency with mem_ready_in tied high: R/I-type 4 cycles, lw 5, sw 4, branch 3, jump 3.
REQ-026 retired_out SHALL increment by 1 on leaving WB_ALU, WB_MEM, BRANCH, JUMP, or MEM_WR with mem_ready_in; wraps 0xFFFFFFFF -> 0.
REQ-027 Wait counter SHALL clear on entering FETCH/MEM_RD/MEM_WR and count each cycle without mem_ready_in; at TIMEOUT_CYCLES consecutive misses -> HALT, timeout_out=1.
REQ-028 mem_ready_in on the same cycle the count reaches TIMEOUT_CYCLES SHALL win (normal transition, no timeout).
REQ-029 mem_ready_in outside FETCH/MEM_RD/MEM_WR SHALL be ignored.
REQ-030 HALT: all strobes 0, state held, flags held until reset.

Reset
REQ-031 reset=0 at a rising edge SHALL force state FETCH, retired_out=0, wait counter 0, illegal_out=0, timeout_out=0.
REQ-032 Strobes SHALL be 0 while reset=0; first mem_read_out=1 in the cycle after reset releases.
REQ-033 Reset mid-access (MEM_RD/MEM_WR) SHALL abort with no reg_write_out or retire.

Structure
REQ-034 Package mc_pkg SHALL hold state encodings, opcode constants, pc_src encodings.
REQ-035 Sub-module mc_wait_timer SHALL implement the REQ-027 counter with clear/count/expired ports.

Verification
REQ-036 R-type 0x00, mem_ready_in=1 -> states 0,1,2,7,0; reg_write_out one cycle with reg_dst_out=1; retired_out=1.
REQ-037 lw 0x23, mem_ready_in low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, then WB_MEM with mem_to_reg_out=1; total 8 cycles.
REQ-038 opcode 0x3F in DECODE -> HALT, illegal_out=1, no strobes for 20 cycles; reset=0 one edge -> FETCH, flags 0.
REQ-039 TIMEOUT_CYCLES=4, mem_ready_in=0 in FETCH -> HALT after 4 cycles, timeout_out=1; variant with ready on cycle 4 -> DECODE.
REQ-040 Preload retired_out near 0xFFFFFFFF via 2 jumps from 0xFFFFFFFE -> 0x00000000 wrap.
REQ-041 reset=0 during MEM_WR -> next cycle FETCH, mem_write_out=0, retired_out=0.
